// File: rtl/bus_select_arbiter.sv
// Registered bus-source select generator: fixed-priority or round-robin
// arbitration with grant hold and conflict monitoring.
module bus_select_arbiter #(
    parameter int N_SOURCES = 32,
    parameter int SEL_W     = $clog2(N_SOURCES),
    parameter int CNT_W     = 8
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [N_SOURCES-1:0] req,
    input  logic                 mode,
    input  logic                 hold,
    output logic [SEL_W-1:0]     sel,
    output logic [N_SOURCES-1:0] grant,
    output logic                 valid,
    output logic                 conflict,
    output logic [CNT_W-1:0]     conflict_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] HELD  = 2'd2;

    localparam logic [SEL_W-1:0] PTR_RESET = SEL_W'(N_SOURCES - 1);

    logic [1:0]           state;
    logic [1:0]           nextState;
    logic [SEL_W-1:0]     ptr;
    logic [SEL_W-1:0]     nextPtr;
    logic [SEL_W-1:0]     nextSel;
    logic [N_SOURCES-1:0] nextGrant;
    logic [SEL_W-1:0]     fixIdx;
    logic [SEL_W-1:0]     rrIdx;
    logic                 rrFound;
    logic                 isConflict;

    function automatic logic [N_SOURCES-1:0] oneHot(input logic [SEL_W-1:0] idx);
        logic [N_SOURCES-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Highest set index wins: later iterations overwrite earlier ones.
    always_comb begin
        fixIdx = '0;
        for (int i = 0; i < N_SOURCES; i++) begin
            if (req[i]) begin
                fixIdx = SEL_W'(i);
            end
        end
    end

    // Search ptr+1 .. ptr+N (mod N) so the last winner is checked last.
    always_comb begin
        rrIdx   = '0;
        rrFound = 1'b0;
        for (int i = 1; i <= N_SOURCES; i++) begin
            if (!rrFound && req[(int'(ptr) + i) % N_SOURCES]) begin
                rrFound = 1'b1;
                rrIdx   = SEL_W'((int'(ptr) + i) % N_SOURCES);
            end
        end
    end

    assign isConflict = (req & (req - 1'b1)) != '0;
    assign valid      = (state != IDLE);

    always_comb begin
        nextState = state;
        nextSel   = sel;
        nextGrant = grant;
        nextPtr   = ptr;
        if (hold && valid) begin
            nextState = HELD;
        end else if (req == '0) begin
            nextState = IDLE;
            nextSel   = '0;
            nextGrant = '0;
        end else begin
            nextState = GRANT;
            if (mode) begin
                nextSel = rrIdx;
                nextPtr = rrIdx;
            end else begin
                nextSel = fixIdx;
            end
            nextGrant = oneHot(nextSel);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state          <= IDLE;
            sel            <= '0;
            grant          <= '0;
            ptr            <= PTR_RESET;
            conflict       <= 1'b0;
            conflict_count <= '0;
        end else begin
            state    <= nextState;
            sel      <= nextSel;
            grant    <= nextGrant;
            ptr      <= nextPtr;
            conflict <= isConflict;
            if (isConflict && conflict_count != '1) begin
                conflict_count <= conflict_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Directed bench for bus_select_arbiter: a 32-source instance for
// arbitration/hold and a 4-source CNT_W=2 instance for saturation.
module tb_bus_select_arbiter;

    logic        clock;
    logic        clear;
    logic [31:0] req;
    logic        mode;
    logic        hold;
    logic [4:0]  sel;
    logic [31:0] grant;
    logic        valid;
    logic        conflict;
    logic [7:0]  conflictCount;

    logic        clear2;
    logic [3:0]  req2;
    logic        mode2;
    logic        hold2;
    logic [1:0]  sel2;
    logic [3:0]  grant2;
    logic        valid2;
    logic        conflict2;
    logic [1:0]  conflictCount2;

    int checks = 0;
    int errors = 0;

    bus_select_arbiter #(.N_SOURCES(32), .CNT_W(8)) dut (
        .clock(clock), .clear(clear), .req(req), .mode(mode), .hold(hold),
        .sel(sel), .grant(grant), .valid(valid), .conflict(conflict),
        .conflict_count(conflictCount)
    );

    bus_select_arbiter #(.N_SOURCES(4), .CNT_W(2)) dutSat (
        .clock(clock), .clear(clear2), .req(req2), .mode(mode2), .hold(hold2),
        .sel(sel2), .grant(grant2), .valid(valid2), .conflict(conflict2),
        .conflict_count(conflictCount2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOut(input string tag, input logic [4:0] eSel,
                            input logic [31:0] eGrant, input logic eValid);
        check({tag, ".sel"}, 64'(sel), 64'(eSel));
        check({tag, ".grant"}, 64'(grant), 64'(eGrant));
        check({tag, ".valid"}, 64'(valid), 64'(eValid));
    endtask

    initial begin
        clear = 1'b1; req = '1; mode = 1'b0; hold = 1'b1;
        clear2 = 1'b1; req2 = '0; mode2 = 1'b0; hold2 = 1'b0;

        // Reset with all requests and hold asserted
        step();
        step();
        checkOut("reset", 5'd0, 32'h0, 1'b0);
        check("reset.conflict", 64'(conflict), 64'd0);
        check("reset.count", 64'(conflictCount), 64'd0);

        // Fixed priority
        clear = 1'b0; hold = 1'b0; req = 32'h0000_0005;
        step();
        checkOut("fix5", 5'd2, 32'h4, 1'b1);
        check("fix5.conflict", 64'(conflict), 64'd1);
        check("fix5.count", 64'(conflictCount), 64'd1);
        req = 32'h8000_0000;
        step();
        checkOut("fix31", 5'd31, 32'h8000_0000, 1'b1);
        check("fix31.conflict", 64'(conflict), 64'd0);
        check("fix31.count", 64'(conflictCount), 64'd1);
        req = 32'h0;
        step();
        checkOut("fixIdle", 5'd0, 32'h0, 1'b0);

        // Round-robin rotation from reset pointer 31
        clear = 1'b1;
        step();
        clear = 1'b0; mode = 1'b1; req = 32'h0000_0013;
        step();
        checkOut("rr0", 5'd0, 32'h1, 1'b1);
        step();
        checkOut("rr1", 5'd1, 32'h2, 1'b1);
        step();
        checkOut("rr2", 5'd4, 32'h10, 1'b1);
        step();
        checkOut("rr3", 5'd0, 32'h1, 1'b1);
        check("rr.count", 64'(conflictCount), 64'd4);

        // Round-robin wrap through 31 to 0
        req = 32'h4000_0000;
        step();
        checkOut("wrap30", 5'd30, 32'h4000_0000, 1'b1);
        req = 32'h8000_0001;
        step();
        checkOut("wrap31", 5'd31, 32'h8000_0000, 1'b1);
        step();
        checkOut("wrap0", 5'd0, 32'h1, 1'b1);

        // Hold in fixed mode, grant frozen while req moves
        mode = 1'b0; req = 32'h0000_0020;
        step();
        checkOut("hold.grant5", 5'd5, 32'h20, 1'b1);
        hold = 1'b1; req = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOut("hold.frozen", 5'd5, 32'h20, 1'b1);
        end
        hold = 1'b0;
        step();
        checkOut("hold.release", 5'd8, 32'h100, 1'b1);
        req = 32'h0;
        step();
        checkOut("hold.idle", 5'd0, 32'h0, 1'b0);
        hold = 1'b1;
        step();
        checkOut("holdIdle1", 5'd0, 32'h0, 1'b0);
        step();
        checkOut("holdIdle2", 5'd0, 32'h0, 1'b0);

        // Hold in RR mode: pointer frozen, search resumes after held index
        hold = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0; mode = 1'b1; req = 32'h0000_0008;
        step();
        checkOut("rrHold.grant3", 5'd3, 32'h8, 1'b1);
        hold = 1'b1; req = 32'h0000_0024;
        step();
        checkOut("rrHold.frozen", 5'd3, 32'h8, 1'b1);
        check("rrHold.conflict", 64'(conflict), 64'd1);
        hold = 1'b0;
        step();
        checkOut("rrHold.release", 5'd5, 32'h20, 1'b1);

        // Clear beats hold
        hold = 1'b1; clear = 1'b1;
        step();
        checkOut("clearHold", 5'd0, 32'h0, 1'b0);
        check("clearHold.count", 64'(conflictCount), 64'd0);
        clear = 1'b0; hold = 1'b0; req = 32'h0;

        // Saturating counter, CNT_W=2
        clear2 = 1'b0; req2 = 4'b0011;
        step();
        check("sat1", 64'(conflictCount2), 64'd1);
        check("sat1.sel", 64'(sel2), 64'd1);
        step();
        check("sat2", 64'(conflictCount2), 64'd2);
        step();
        check("sat3", 64'(conflictCount2), 64'd3);
        step();
        check("sat4", 64'(conflictCount2), 64'd3);
        step();
        check("sat5", 64'(conflictCount2), 64'd3);
        clear2 = 1'b1;
        step();
        check("satClear", 64'(conflictCount2), 64'd0);
        check("satClear.valid", 64'(valid2), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_select_arbiter.md
# bus_select_arbiter

Parametrised, registered bus-source select generator for the datapath bus multiplexer. It takes N per-source out-enable requests and produces a one-hot grant, a binary mux select and a valid flag. Fixed-priority or round-robin arbitration is chosen at run time, with grant hold and conflict monitoring. It sits between the control unit's out-enable strobes and the bus mux select input, and adds one register stage to the select path.

## Interface
- `N_SOURCES`, 32: number of bus sources; must be ≥ 2.
- `SEL_W`, `$clog2(N_SOURCES)`: select width.
- `CNT_W`, 8: conflict counter width.

- `clock`  in  1  rising-edge clock.
- `clear`  in  1  reset, synchronous, active-high.
- `req`  in  N_SOURCES  per-source out-enable request; bit i = source i.
- `mode`  in  1  0 = fixed priority (highest index wins), 1 = round-robin.
- `hold`  in  1  freeze the current grant while asserted.
- `sel`  out  SEL_W  registered binary index of the granted source.
- `grant`  out  N_SOURCES  registered one-hot grant; all-zero when idle.
- `valid`  out  1  registered; 1 when `grant` is non-zero.
- `conflict`  out  1  registered; 1 when more than one `req` bit was set in the sampled cycle.
- `conflict_count`  out  CNT_W  saturating count of conflict cycles.

## Operation
- Reset (`clear`=1 at a clock edge): `sel`=0, `grant`=0, `valid`=0, `conflict`=0, `conflict_count`=0, internal round-robin pointer `ptr`=N_SOURCES-1. `clear` overrides all other inputs, including `hold`.
- States: IDLE (`valid`=0), GRANT (`valid`=1, re-arbitrated every cycle), HELD (`valid`=1, `hold`=1).
- IDLE or GRANT, `req`=0: next state IDLE, with `sel`=0 and `grant`=0.
- IDLE or GRANT, `req`≠0, `mode`=0: grant the highest set index. `ptr` is unchanged.
- IDLE or GRANT, `req`≠0, `mode`=1:
  - Search indices `ptr`+1, `ptr`+2, … with wrap modulo N_SOURCES; `ptr` itself is checked last.
  - Grant the first set bit and load `ptr` with that index.
- `hold`=1 with `valid`=1: enter or stay in HELD.
  - `sel`, `grant` and `ptr` stay frozen regardless of `req` and `mode`.
  - This holds even if the held source's `req` bit drops.
- `hold`=1 with `valid`=0: no effect; arbitrate normally. A grant made this cycle becomes frozen from the next cycle if `hold` stays high.
- Leaving HELD: on the first edge with `hold`=0, arbitrate normally. In RR mode the search starts from the held index + 1.
- `mode` change: takes effect at the next edge. `ptr` is retained across mode changes.
- `sel` always equals the binary encoding of `grant`. `grant` is never multi-hot.
- `conflict` is computed from the sampled `req` every cycle, including in HELD.
- `conflict_count` increments by 1 on each edge where the sampled `req` has popcount > 1. It saturates at 2^CNT_W-1 and clears only by `clear`.

## Timing
- Latency is one cycle. `req`, `mode` and `hold` are sampled at edge k; `sel`, `grant`, `valid` and `conflict` reflect them after edge k. `conflict_count` reflects the cycle-k sample after edge k.
- There is no combinational path from inputs to outputs.
- Simultaneous `clear` and `hold`: `clear` wins, and outputs are reset at that edge.
- Throughput: a new grant is possible every cycle.

## Test plan
- Reset: drive `clear`=1 for 2 cycles with `req`=all-ones and `hold`=1 → `sel`=0, `grant`=0, `valid`=0, `conflict_count`=0.
- Fixed priority, N=32: `req`=0x0000_0005 → next cycle `sel`=2, `grant`=0x4, `conflict`=1, count=1. Then `req`=0x8000_0000 → `sel`=31. Then `req`=0 → `valid`=0, `sel`=0.
- Round-robin rotation: `mode`=1, `req`=0x0000_0013 held for 4 cycles after reset.
  - `sel` sequence must be 0, 1, 4, 0.
  - `conflict_count` must be 4.
- RR wrap: with `ptr`=30 (set by granting source 30), apply `req`=bit31|bit0 → `sel`=31, then `sel`=0.
- Hold: grant `sel`=5, then `hold`=1 and `req`=0x0000_0100 for 3 cycles → `sel` stays 5 with `valid`=1. Release `hold` → `sel`=8 one cycle later. `hold`=1 with `req`=0 from IDLE → `valid` stays 0.
- Saturation: CNT_W=2 with 5 consecutive conflict cycles → `conflict_count` reads 1, 2, 3, 3, 3. Pulse `clear` → 0.
